fifo_rd_arbiter: RTL and testbench

Read-domain controller for the asynchronous FIFO. It takes the two-stage-synchronized Gray write pointer, keeps the read pointer and the registered empty flag, and shares the single FIFO read port among NREQ consumers. Sharing is round-robin with bounded bursts. It drives the memory read address and the Gray read pointer that is returned to the write domain, and tags each read with the consumer it belongs to.

---
 rtl/fifo_rd_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter
// Description : Read-domain controller of the asynchronous FIFO. It owns the
//               read pointer and the registered empty flag, and it shares the
//               single FIFO read port among NREQ consumers. Sharing is
//               round-robin, and each grant is a burst bounded by MAXBURST.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
    parameter  int ADDRSIZE = 4,
    parameter  int NREQ     = 4,
    parameter  int MAXBURST = 4,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     grant,
    output logic                rinc,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                rvalid,
    output logic [IDW-1:0]      rid
);

    // The burst counter must be able to hold MAXBURST-1.
    localparam int             c_cnt_w    = $clog2(MAXBURST + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(MAXBURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               r_state, w_state_next;
    logic [IDW-1:0]       r_owner, w_owner_next;
    logic [IDW-1:0]       r_last_owner, w_last_owner_next;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
    logic [ADDRSIZE:0]    r_rbin, r_rptr;
    logic                 r_rempty, r_rvalid;
    logic [IDW-1:0]       r_rid;
    logic [ADDRSIZE:0]    w_rbinnext, w_rgraynext;
    logic                 w_rinc;
    logic                 w_found;
    logic [IDW-1:0]       w_winner;
    int                   w_idx;

    // Round-robin search: first requester above the previous owner, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_owner;
        w_idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = (int'(r_last_owner) + i) % NREQ;
            if (!w_found && req[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IDW-1:0];
            end
        end
    end

    // Arbitration FSM: next state, burst bookkeeping and the read strobe.
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_cnt_next        = r_cnt;
        w_rinc            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rempty && w_found) begin
                    w_state_next = ST_BURST;
                    w_owner_next = w_winner;
                    w_cnt_next   = '0;
                end
            end
            ST_BURST: begin
                // The registered empty flag gates the strobe, so an underflow cannot occur.
                w_rinc = req[r_owner] & ~r_rempty;
                if (w_rinc) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if ((w_rinc && (r_cnt == c_last_cnt)) || !req[r_owner] || r_rempty) begin
                    w_state_next      = ST_IDLE;
                    w_last_owner_next = r_owner;
                    w_cnt_next        = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= IDW'(NREQ - 1);
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_cnt        <= w_cnt_next;
        end
    end

    assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_rinc};
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

    // Read pointer, Gray pointer and empty flag. Empty uses the next Gray value,
    // so the flag rises on the same edge that consumes the last entry.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin   <= '0;
            r_rptr   <= '0;
            r_rempty <= 1'b1;
        end else begin
            r_rbin   <= w_rbinnext;
            r_rptr   <= w_rgraynext;
            r_rempty <= (w_rgraynext == rq2_wptr);
        end
    end

    // Beat tag aligned with synchronous-read memory data; rid keeps the last
    // owner while no beat is valid.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= w_rinc;
            if (w_rinc) begin
                r_rid <= r_owner;
            end
        end
    end

    // Grant is the one-hot owner for the duration of a burst.
    always_comb begin
        grant = '0;
        if (r_state == ST_BURST) begin
            grant[r_owner] = 1'b1;
        end
    end

    assign rinc   = w_rinc;
    assign raddr  = r_rbin[ADDRSIZE-1:0];
    assign rptr   = r_rptr;
    assign rempty = r_rempty;
    assign rvalid = r_rvalid;
    assign rid    = r_rid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_arbiter
// Description : Self-checking bench for fifo_rd_arbiter. The bench plays the
//               write side (pointer model), keeps a reference read pointer and
//               a scoreboard of expected beat owners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

    localparam int ADDRSIZE = 4;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 4;

    logic       rclk   = 1'b0;
    logic       rrst_n = 1'b1;
    logic [4:0] rq2_wptr = '0;
    logic [3:0] req      = '0;
    logic [3:0] grant;
    logic       rinc;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       rvalid;
    logic [1:0] rid;

    int         n_pass  = 0;
    int         n_total = 0;
    int         wcnt    = 0;
    int         rd_cnt  = 0;
    logic [4:0] wptr_prev = '0;
    logic [1:0] sb_q[$];

    typedef struct {
        logic [3:0] req;
        int         entries;
        logic [3:0] exp_grant;
        int         exp_reads;
    } vec_t;

    fifo_rd_arbiter #(
        .ADDRSIZE (ADDRSIZE),
        .NREQ     (NREQ),
        .MAXBURST (MAXBURST)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rq2_wptr (rq2_wptr),
        .req      (req),
        .grant    (grant),
        .rinc     (rinc),
        .raddr    (raddr),
        .rptr     (rptr),
        .rempty   (rempty),
        .rvalid   (rvalid),
        .rid      (rid)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return (x >> 1) ^ x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge rclk);
    endtask

    task automatic set_w(input int n);
        wcnt     = n;
        rq2_wptr = gray(n);
    endtask

    task automatic push_ids(input int id, input int n);
        for (int k = 0; k < n; k++) sb_q.push_back(2'(id));
    endtask

    // Ends at a negedge where grant is non-zero, or reports a timeout.
    task automatic wait_grant(input int bound);
        int waited;
        waited = 0;
        at_neg();
        while (grant == 4'b0 && waited < bound) begin
            step();
            at_neg();
            waited++;
        end
        if (grant == 4'b0) chk("grant_timeout", 32'(grant != 4'b0), 1);
    endtask

    // Counts read strobes until grant drops; ends at a negedge with grant == 0.
    task automatic count_burst(output int reads);
        int guard;
        reads = 0;
        guard = 0;
        while (grant != 4'b0 && guard < 40) begin
            if (rinc) reads++;
            step();
            at_neg();
            guard++;
        end
        if (grant != 4'b0) chk("burst_timeout", 32'(grant), 0);
    endtask

    // Reference read pointer, empty flag and scoreboard of rvalid beats.
    always @(negedge rclk) begin
        if (!rrst_n) begin
            rd_cnt    = 0;
            wptr_prev = rq2_wptr;
        end else begin
            chk("rptr_gray", 32'(rptr), 32'(gray(rd_cnt)));
            chk("rempty", 32'(rempty), 32'(gray(rd_cnt) == wptr_prev));
            if (rinc) begin
                chk("no_underflow", 32'((wcnt - rd_cnt) > 0), 1);
                chk("raddr", 32'(raddr), rd_cnt % 16);
                rd_cnt++;
            end
            if (rvalid) begin
                if (sb_q.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 0);
                else                  chk("rid", 32'(rid), 32'(sb_q.pop_front()));
            end
            wptr_prev = rq2_wptr;
        end
    end

    initial begin
        vec_t vecs[5];
        int   reads;
        int   gap;
        int   start;
        int   target;
        int   written;
        int   guard;
        int   id;

        vecs[0] = '{req: 4'b0010, entries: 2, exp_grant: 4'b0010, exp_reads: 2};
        vecs[1] = '{req: 4'b0011, entries: 4, exp_grant: 4'b0001, exp_reads: 4};
        vecs[2] = '{req: 4'b1001, entries: 1, exp_grant: 4'b1000, exp_reads: 1};
        vecs[3] = '{req: 4'b0100, entries: 3, exp_grant: 4'b0100, exp_reads: 3};
        vecs[4] = '{req: 4'b1010, entries: 4, exp_grant: 4'b1000, exp_reads: 4};

        // Reset, then a request against an empty FIFO.
        #2;
        rrst_n = 1'b0;
        set_w(0);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_rptr", 32'(rptr), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        step();
        step();
        rrst_n = 1'b1;
        req    = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("empty_grant", 32'(grant), 0);
            chk("empty_rinc", 32'(rinc), 0);
            chk("empty_rempty", 32'(rempty), 1);
            step();
        end

        // Three entries to consumer 0: cycle-accurate latency sequence.
        set_w(3);
        push_ids(0, 3);
        at_neg();
        chk("t2_rempty_before", 32'(rempty), 1);
        step(); at_neg();
        chk("t2_rempty_drop", 32'(rempty), 0);
        chk("t2_idle_grant", 32'(grant), 0);
        for (int k = 0; k < 3; k++) begin
            step(); at_neg();
            chk("t2_grant", 32'(grant), 1);
            chk("t2_rinc", 32'(rinc), 1);
        end
        step(); at_neg();
        chk("t2_rempty_rise", 32'(rempty), 1);
        chk("t2_rinc_stop", 32'(rinc), 0);
        step(); at_neg();
        chk("t2_back_idle", 32'(grant), 0);
        step();
        req = 4'b0000;

        // Table of single bursts exercising the round-robin pointer.
        for (int v = 0; v < 5; v++) begin
            step();
            set_w(wcnt + vecs[v].entries);
            req = vecs[v].req;
            id  = 0;
            for (int k = 0; k < 4; k++) if (vecs[v].exp_grant[k]) id = k;
            push_ids(id, vecs[v].exp_reads);
            wait_grant(6);
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
            count_burst(reads);
            chk($sformatf("vec%0d_reads", v), reads, vecs[v].exp_reads);
            step();
            req = 4'b0000;
        end

        // Sixteen entries, all consumers requesting: four full bursts.
        step();
        set_w(wcnt + 16);
        req = 4'b1111;
        for (int b = 0; b < 4; b++) push_ids(b, 4);
        for (int b = 0; b < 4; b++) begin
            if (b == 0) begin
                wait_grant(6);
            end else begin
                gap = 1;
                step(); at_neg();
                while (grant == 4'b0 && gap < 6) begin
                    gap++;
                    step(); at_neg();
                end
                chk("rr_idle_gap", gap, 1);
            end
            chk("rr_grant", 32'(grant), 1 << b);
            count_burst(reads);
            chk("rr_reads", reads, MAXBURST);
        end
        step();
        req = 4'b0000;

        // Owner drops its request after two reads.
        step();
        set_w(wcnt + 6);
        req = 4'b0101;
        push_ids(0, 2);
        push_ids(2, 4);
        wait_grant(6);
        chk("drop_grant0", 32'(grant), 1);
        step(); at_neg();
        chk("drop_read2", 32'(rinc), 1);
        step();
        req = 4'b0100;
        at_neg();
        chk("drop_rinc", 32'(rinc), 0);
        step(); at_neg();
        chk("drop_idle", 32'(grant), 0);
        step(); at_neg();
        chk("drop_next_grant", 32'(grant), 4);
        count_burst(reads);
        chk("drop_next_reads", reads, MAXBURST);
        step();
        req = 4'b0000;

        // Forty reads through the depth-16 FIFO, wrapping the pointer.
        step();
        start   = rd_cnt;
        target  = start + 40;
        written = 0;
        guard   = 0;
        req     = 4'b0010;
        push_ids(1, 40);
        while (rd_cnt < target && guard < 400) begin
            if (written < 40 && (wcnt - rd_cnt) < 16) begin
                set_w(wcnt + 1);
                written++;
            end
            step();
            guard++;
        end
        at_neg();
        chk("wrap_reads", rd_cnt, target);
        step();
        req = 4'b0000;
        step(); step(); at_neg();
        chk("wrap_rempty", 32'(rempty), 1);
        chk("wrap_rptr", 32'(rptr), 32'(gray(target)));
        chk("wrap_grant", 32'(grant), 0);

        // Asynchronous reset in the middle of a burst.
        step();
        set_w(wcnt + 4);
        req = 4'b0100;
        push_ids(2, 1);
        wait_grant(6);
        chk("rstmid_grant", 32'(grant), 4);
        step(); at_neg();
        chk("rstmid_read2", 32'(rinc), 1);
        #1;
        rrst_n = 1'b0;
        set_w(0);
        #1;
        chk("rstmid_grant0", 32'(grant), 0);
        chk("rstmid_rinc", 32'(rinc), 0);
        chk("rstmid_rempty", 32'(rempty), 1);
        chk("rstmid_rptr", 32'(rptr), 0);
        chk("rstmid_raddr", 32'(raddr), 0);
        chk("rstmid_rvalid", 32'(rvalid), 0);
        chk("rstmid_rid", 32'(rid), 0);
        step();
        step();
        chk("rstmid_sb_drained", sb_q.size(), 0);
        rrst_n = 1'b1;
        req    = 4'b0101;
        set_w(2);
        push_ids(0, 2);
        wait_grant(6);
        chk("post_rst_grant", 32'(grant), 1);
        count_burst(reads);
        chk("post_rst_reads", reads, 2);
        step();
        req = 4'b0000;
        step(); step(); at_neg();
        chk("sb_final_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
